// File: rtl/discr_scaler_1b.sv
// Counts uninhibited discriminator rising edges over a programmable gate period.
// Optional deadtime accumulator enabled by defining DISCR_SCALER_DEADTIME_EN.
module discr_scaler_1b #(
    parameter int unsigned P_PERIOD_WIDTH = 32,
    parameter int unsigned P_CNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bits_in,
    input  logic                      inhibit_in,
    input  logic [P_PERIOD_WIDTH-1:0] period_len,
    output logic [P_CNT_WIDTH-1:0]    scaler_out,
    output logic [P_CNT_WIDTH-1:0]    deadtime_out,
    output logic [15:0]               period_seq,
    output logic                      valid
);

    localparam logic [0:0] S_DISABLED = 1'b0;
    localparam logic [0:0] S_COUNT    = 1'b1;

    localparam logic [P_CNT_WIDTH-1:0]    CNT_MAX    = '1;
    localparam logic [P_PERIOD_WIDTH-1:0] PERIOD_ONE = P_PERIOD_WIDTH'(1);

    logic [P_PERIOD_WIDTH-1:0] i_period_len;
    logic [P_PERIOD_WIDTH-1:0] pcnt;
    logic [P_CNT_WIDTH-1:0]    racc;
    logic [P_CNT_WIDTH-1:0]    racc_next;
    logic                      prev_bit;
    logic                      bit_edge;
    logic                      rinc;
    logic                      dinc;
    logic [0:0]                state;
    logic                      final_cycle;

    function automatic logic [P_CNT_WIDTH-1:0] sat_inc(input logic [P_CNT_WIDTH-1:0] acc,
                                                       input logic inc);
        sat_inc = (acc == CNT_MAX) ? acc : acc + P_CNT_WIDTH'(inc);
    endfunction

    // State follows the registered period length; zero means the scaler is off.
    assign state       = (i_period_len == '0) ? S_DISABLED : S_COUNT;
    assign bit_edge    = bits_in & ~prev_bit;
    assign rinc        = bit_edge & ~inhibit_in;
    assign dinc        = inhibit_in;
    assign final_cycle = (state == S_COUNT) && (pcnt >= (i_period_len - PERIOD_ONE));

    always_comb begin
        racc_next = sat_inc(racc, rinc);
    end

    // Edge history and period length register run through reset as well.
    always_ff @(posedge clk) begin
        i_period_len <= period_len;
        prev_bit     <= bits_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            racc       <= '0;
            scaler_out <= '0;
            period_seq <= '0;
            valid      <= 1'b0;
        end else if (state == S_DISABLED) begin
            pcnt  <= '0;
            racc  <= '0;
            valid <= 1'b0;
        end else if (final_cycle) begin
            scaler_out <= racc_next;
            racc       <= '0;
            pcnt       <= '0;
            period_seq <= period_seq + 16'd1;
            valid      <= 1'b1;
        end else begin
            racc  <= racc_next;
            pcnt  <= pcnt + PERIOD_ONE;
            valid <= 1'b0;
        end
    end

`ifdef DISCR_SCALER_DEADTIME_EN
    logic [P_CNT_WIDTH-1:0] dacc;
    logic [P_CNT_WIDTH-1:0] dacc_next;

    always_comb begin
        dacc_next = sat_inc(dacc, dinc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dacc         <= '0;
            deadtime_out <= '0;
        end else if (state == S_DISABLED) begin
            dacc <= '0;
        end else if (final_cycle) begin
            deadtime_out <= dacc_next;
            dacc         <= '0;
        end else begin
            dacc <= dacc_next;
        end
    end
`else
    logic unused_dinc;
    assign unused_dinc  = dinc;
    assign deadtime_out = '0;
`endif

endmodule

// File: tb/tb_discr_scaler_1b.sv
// Directed self-checking bench for discr_scaler_1b (32-bit and 4-bit counter instances).
module tb_discr_scaler_1b;

`ifdef DISCR_SCALER_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bits_in = 1'b0;
    logic        inhibit_in = 1'b0;
    logic [31:0] period_len = '0;
    logic [31:0] scaler_out, deadtime_out;
    logic [15:0] period_seq;
    logic        valid;
    logic [3:0]  scaler_s, deadtime_s;
    logic [15:0] seq_s;
    logic        valid_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    discr_scaler_1b dut (
        .clk(clk), .rst(rst), .bits_in(bits_in), .inhibit_in(inhibit_in),
        .period_len(period_len), .scaler_out(scaler_out), .deadtime_out(deadtime_out),
        .period_seq(period_seq), .valid(valid)
    );

    discr_scaler_1b #(.P_PERIOD_WIDTH(32), .P_CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .bits_in(bits_in), .inhibit_in(inhibit_in),
        .period_len(period_len), .scaler_out(scaler_s), .deadtime_out(deadtime_s),
        .period_seq(seq_s), .valid(valid_s)
    );

    task automatic step(input logic b, input logic inh);
        bits_in    = b;
        inhibit_in = inh;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        period_len = '0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        period_len = 32'd5;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (scaler_out !== 32'd0) begin
            errors++; $display("FAIL reset_scaler: got %0d want 0", scaler_out);
        end
        checks++;
        if (deadtime_out !== 32'd0) begin
            errors++; $display("FAIL reset_deadtime: got %0d want 0", deadtime_out);
        end
        checks++;
        if (period_seq !== 16'd0) begin
            errors++; $display("FAIL reset_seq: got %0d want 0", period_seq);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid);
        end
    endtask

    // Period 10, three clean pulses.
    task automatic test_basic();
        logic pat [10] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        do_reset();
        period_len = 32'd10;
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(pat[i], 1'b0);
            if (i == 8) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++; $display("FAIL basic_early_valid: got %b want 0", valid);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd3 || deadtime_out !== 32'd0
            || period_seq !== 16'd1) begin
            errors++;
            $display("FAIL basic_result: valid=%b scaler=%0d dead=%0d seq=%0d want 1/3/0/1",
                     valid, scaler_out, deadtime_out, period_seq);
        end
        step(1'b0, 1'b0);
        checks++;
        if (valid !== 1'b0 || scaler_out !== 32'd3) begin
            errors++;
            $display("FAIL basic_strobe_len: valid=%b scaler=%0d want 0/3", valid, scaler_out);
        end
    endtask

    // Period 20, the second pulse edge falls inside a 5-cycle inhibit window.
    task automatic test_inhibit();
        logic [31:0] exp_dead;
        exp_dead = DT_EN ? 32'd5 : 32'd0;
        do_reset();
        period_len = 32'd20;
        step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step((i == 1) || (i == 5) || (i == 9) || (i == 13), (i >= 4) && (i <= 8));
        end
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd3) begin
            errors++;
            $display("FAIL inhibit_scaler: valid=%b scaler=%0d want 1/3", valid, scaler_out);
        end
        checks++;
        if (deadtime_out !== exp_dead) begin
            errors++;
            $display("FAIL inhibit_deadtime: got %0d want %0d", deadtime_out, exp_dead);
        end
    endtask

    // 20 edges in a 100-cycle period saturate the 4-bit instance at 15.
    task automatic test_saturation();
        do_reset();
        period_len = 32'd100;
        step(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step((i < 40) && (i % 2 == 0), 1'b0);
            if (i == 98) begin
                checks++;
                if (valid_s !== 1'b0) begin
                    errors++; $display("FAIL sat_early_valid: got %b want 0", valid_s);
                end
            end
        end
        checks++;
        if (valid_s !== 1'b1 || scaler_s !== 4'd15 || seq_s !== 16'd1) begin
            errors++;
            $display("FAIL sat_narrow: valid=%b scaler=%0d seq=%0d want 1/15/1",
                     valid_s, scaler_s, seq_s);
        end
        checks++;
        if (scaler_out !== 32'd20) begin
            errors++; $display("FAIL sat_wide: got %0d want 20", scaler_out);
        end
    endtask

    // Period 1: every cycle final, alternating counts, 16-bit sequence wrap.
    task automatic test_period_one();
        int bad = 0;
        do_reset();
        period_len = 32'd1;
        step(1'b0, 1'b0);
        for (int n = 1; n <= 65536; n++) begin
            step(n % 2 == 1, 1'b0);
            if (valid !== 1'b1 || scaler_out !== ((n % 2 == 1) ? 32'd1 : 32'd0)) bad++;
            if (n <= 3 || n == 65535) begin
                checks++;
                if (period_seq !== 16'(n)) begin
                    errors++; $display("FAIL p1_seq_%0d: got %0d want %0d", n, period_seq, 16'(n));
                end
            end
            if (n == 65536) begin
                checks++;
                if (period_seq !== 16'd0) begin
                    errors++; $display("FAIL p1_seq_wrap: got %0d want 0", period_seq);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL p1_alternate: %0d bad cycles, want 0", bad);
        end
    endtask

    // Level held through reset is not an edge; disabling mid-period discards it.
    task automatic test_hold_and_disable();
        int bad = 0;
        rst        = 1'b1;
        period_len = 32'd10;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd0 || period_seq !== 16'd1) begin
            errors++;
            $display("FAIL hold_no_edge: valid=%b scaler=%0d seq=%0d want 1/0/1",
                     valid, scaler_out, period_seq);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        period_len = 32'd0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            if (valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL disable_no_valid: %0d valid cycles, want 0", bad);
        end
        period_len = 32'd10;
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (i == 8) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++; $display("FAIL reenable_early_valid: got %b want 0", valid);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd0 || period_seq !== 16'd2) begin
            errors++;
            $display("FAIL reenable_result: valid=%b scaler=%0d seq=%0d want 1/0/2",
                     valid, scaler_out, period_seq);
        end
    endtask

    // Reset mid-period clears outputs and discards the partial count.
    task automatic test_mid_reset();
        logic [31:0] exp_dead;
        exp_dead = DT_EN ? 32'd2 : 32'd0;
        do_reset();
        period_len = 32'd10;
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(i == 2, 1'b0);
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd1 || period_seq !== 16'd1) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b scaler=%0d seq=%0d want 1/1/1",
                     valid, scaler_out, period_seq);
        end
        for (int i = 0; i < 7; i++) step((i == 1) || (i == 3), 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || scaler_out !== 32'd0 || period_seq !== 16'd0
            || deadtime_out !== 32'd0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%b scaler=%0d seq=%0d dead=%0d want 0/0/0/0",
                     valid, scaler_out, period_seq, deadtime_out);
        end
        for (int i = 0; i < 10; i++) step(i == 4, (i == 6) || (i == 7));
        checks++;
        if (valid !== 1'b1 || scaler_out !== 32'd1 || period_seq !== 16'd1) begin
            errors++;
            $display("FAIL midrst_next: valid=%b scaler=%0d seq=%0d want 1/1/1",
                     valid, scaler_out, period_seq);
        end
        checks++;
        if (deadtime_out !== exp_dead) begin
            errors++; $display("FAIL midrst_dead: got %0d want %0d", deadtime_out, exp_dead);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inhibit();
        test_saturation();
        test_period_one();
        test_hold_and_disable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
